muxn_1_rr_reg: RTL
==================

Name: muxn_1_rr_reg

Overview:
- Parametrised successor to the 2:1 2-bit registered mux: N input channels, WIDTH-bit data, registered output.
- Adds per-channel valid/ready handshakes and a one-entry output register with downstream backpressure.
- Two selection modes: fixed (external selector) and round-robin arbitration.
- Sits between multiple producers and a single consumer in the datapath test structures.

Parameters:
- WIDTH, 2, data bits per channel.
- N, 4, number of input channels (2..16).
- SEL_W, $clog2(N), selector width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- data_in  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- valid_in  input  N  channel i presents valid data.
- ready_out  output  N  channel i word accepted this cycle (combinational).
- selector  input  SEL_W  channel index used in fixed mode.
- mode  input  1  0 = fixed selector, 1 = round-robin.
- data_out  output  WIDTH  registered output word.
- valid_out  output  1  data_out holds an unconsumed word.
- ready_in  input  1  downstream accepts data_out this cycle.

Behaviour:
- Reset, asynchronous: data_out=0, valid_out=0, round-robin pointer rr_ptr=0. Takes effect immediately, including mid-transfer; the held word is discarded.
- accept = !valid_out | ready_in. The output register may load only when accept=1.
- Fixed mode (mode=0):
  - grant = selector.
  - ready_out[selector] = accept; all other ready_out bits = 0.
  - selector >= N: no grant, ready_out = 0, nothing loaded.
- Round-robin mode (mode=1):
  - grant = first channel with valid_in=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo N.
  - ready_out[grant] = accept, only if some valid_in is set.
- Transfer on channel g when valid_in[g] & ready_out[g].
- On the clock edge after a transfer:
  - data_out <= data_in[g]; valid_out <= 1.
  - In round-robin mode only, rr_ptr <= (g+1) mod N, wrapping N-1 -> 0.
- Pop without load (valid_out & ready_in, no transfer): valid_out <= 0; data_out holds its last value.
- Simultaneous pop and load: valid_out stays 1 and data_out takes the new word. Full throughput is one word per cycle.
- Backpressure (valid_out=1, ready_in=0): all ready_out = 0; data_out and valid_out hold; rr_ptr holds.
- Latency: input transfer -> data_out/valid_out update on the next rising edge (1 cycle).
- Mode or selector change: sampled combinationally each cycle. rr_ptr is retained across mode switches.
- No valid_in set: ready_out = 0; rr_ptr holds.

Optional Feature:
- Macro: MUXN_PARITY_EN.
- When defined:
  - Adds output port parity_out (1 bit): even parity (XOR reduction) of the loaded word.
  - Registered together with data_out; reset value 0.
  - Holds whenever data_out holds.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-operation: assert reset with valid_out=1 and data_out=2'b11 -> data_out=0 and valid_out=0 immediately, no clock edge needed; after release, rr_ptr=0 and channel 0 wins first.
- Fixed mode: N=4, mode=0, selector=2, all valid_in=1, data_in channels = 0,1,2,3, ready_in=1 -> ready_out=4'b0100; data_out=2 with valid_out=1 one cycle later, sustained every cycle.
- Round-robin fairness: mode=1, valid_in=4'b1111, ready_in=1 -> grants 0,1,2,3,0 on consecutive cycles; data_out sequence 0,1,2,3,0.
- Round-robin skip and wrap: valid_in=4'b1001 with rr_ptr=1 -> grant 3, then rr_ptr=0, then grant 0.
- Backpressure: word 3 held, ready_in=0 for 3 cycles while valid_in=4'b1111 -> ready_out=0, data_out=3 stable, rr_ptr unchanged. Raise ready_in -> simultaneous pop and load, valid_out stays 1.
- Fixed mode out of range: N=3, selector=3 -> ready_out=0, valid_out falls to 0 after the pending word is popped. With MUXN_PARITY_EN, loading 2'b01 gives parity_out=1 and loading 2'b11 gives parity_out=0.

Source files
------------

// File: rtl/muxn_1_rr_reg_if.sv
// Channel-side and consumer-side bus of the N:1 registered mux.
// MUXN_PARITY_EN adds parity_out alongside data_out.
interface muxn_1_rr_reg_if #(
    parameter int WIDTH = 2,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic [N*WIDTH-1:0] data_in;
    logic [N-1:0]       valid_in;
    logic [N-1:0]       ready_out;
    logic [SEL_W-1:0]   selector;
    logic               mode;
    logic [WIDTH-1:0]   data_out;
    logic               valid_out;
    logic               ready_in;
`ifdef MUXN_PARITY_EN
    logic               parity_out;
`endif

    modport master (
        output data_in, valid_in, selector, mode, ready_in,
`ifdef MUXN_PARITY_EN
        input  parity_out,
`endif
        input  ready_out, data_out, valid_out
    );

    modport slave (
        input  data_in, valid_in, selector, mode, ready_in,
`ifdef MUXN_PARITY_EN
        output parity_out,
`endif
        output ready_out, data_out, valid_out
    );
endinterface

// File: rtl/muxn_1_rr_reg.sv
// N:1 mux with per-channel valid/ready, fixed or round-robin selection and a
// one-entry output register. Define MUXN_PARITY_EN to add a registered parity_out.
module muxn_1_rr_reg #(
    parameter int WIDTH = 2,
    parameter int N     = 4
) (
    input  logic          clk,
    input  logic          reset,
    muxn_1_rr_reg_if.slave bus
);
    localparam int SEL_W = $clog2(N);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0] grant;
    logic             have_grant;
    logic             accept;
    logic             xfer;
    logic [N-1:0]     ready;
    logic [WIDTH-1:0] grant_word;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    int               rr_idx;

    always_comb begin
        accept     = !valid_q || bus.ready_in;
        grant      = '0;
        have_grant = 1'b0;
        rr_idx     = 0;
        if (!bus.mode) begin
            // Out-of-range selectors match no channel and leave have_grant low.
            for (int i = 0; i < N; i++) begin
                if (bus.selector == SEL_W'(i)) begin
                    grant      = SEL_W'(i);
                    have_grant = 1'b1;
                end
            end
        end else begin
            // Scan farthest offset first so the channel nearest rr_ptr wins.
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx = int'(rr_ptr_q) + k;
                if (rr_idx >= N) begin
                    rr_idx = rr_idx - N;
                end
                if (bus.valid_in[rr_idx]) begin
                    grant      = SEL_W'(rr_idx);
                    have_grant = 1'b1;
                end
            end
        end

        ready      = '0;
        grant_word = '0;
        for (int i = 0; i < N; i++) begin
            if (have_grant && grant == SEL_W'(i)) begin
                ready[i]   = accept;
                grant_word = bus.data_in[i*WIDTH +: WIDTH];
            end
        end
        xfer = |(ready & bus.valid_in);

        rr_ptr_d = rr_ptr_q;
        if (xfer && bus.mode) begin
            rr_ptr_d = (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
        end
    end

`ifdef MUXN_PARITY_EN
    logic parity_q;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
`ifdef MUXN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (xfer) begin
                data_q  <= grant_word;
                valid_q <= 1'b1;
`ifdef MUXN_PARITY_EN
                parity_q <= ^grant_word;
`endif
            end else if (valid_q && bus.ready_in) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.ready_out = ready;
    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
`ifdef MUXN_PARITY_EN
    assign bus.parity_out = parity_q;
`endif
endmodule
